mixcol_seq: RTL and testbench



---
 rtl/mixcol_seq.sv | 181 ++++++++++++++++++
 tb/tb_mixcol_seq.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mixcol_seq.sv
// mixcol_seq: multi-cycle AES MixColumns engine.
// COLS_PER_CYCLE column units (1, 2 or 4) are time-shared over the four
// state columns. A valid/ready handshake is used on both input and output.
// Optional feature: define AES_MIXCOL_INV_EN to add InvMixColumns, selected
// by the inv port at accept time. Without the macro, inv is ignored and only
// the forward transform is built.
module mixcol_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    // Reject unsupported column-unit counts at elaboration.
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
        $error("mixcol_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // col_cnt advance per BUSY cycle (4 wraps to 0, which is never observed)
    localparam logic [1:0] STEP     = COLS_PER_CYCLE[1:0];
    // Starting column of the final BUSY cycle
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   col_cnt;
    logic [127:0] src;
    logic [127:0] res;
    logic [127:0] res_next;
    logic         mode;

    // GF(2^8) multiply by 2, reduction polynomial 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns on one 32-bit column, a0 in the MSB byte
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, d3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        return {d0 ^ d1 ^ a1 ^ a2 ^ a3,
                a0 ^ d1 ^ d2 ^ a2 ^ a3,
                a0 ^ a1 ^ d2 ^ d3 ^ a3,
                d0 ^ a0 ^ a1 ^ a2 ^ d3};
    endfunction

`ifdef AES_MIXCOL_INV_EN
    // Inverse MixColumns; 9/11/13/14 built from the x2/x4/x8 chain
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] m9 [4];
        logic [7:0] m11 [4];
        logic [7:0] m13 [4];
        logic [7:0] m14 [4];
        logic [7:0] x2, x4, x8;
        for (int i = 0; i < 4; i++) begin
            a[i]   = col[31-8*i -: 8];
            x2     = xtime(a[i]);
            x4     = xtime(x2);
            x8     = xtime(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic m);
        return m ? mix_inv(col) : mix_fwd(col);
    endfunction
`else
    // Forward-only build: the mode register is a constant 0
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic m);
        logic unused_m;
        unused_m = m;
        return mix_fwd(col);
    endfunction

    logic unused_inv;
    assign unused_inv = inv;
`endif

    // Compute this cycle's columns and merge them into the result image
    always_comb begin
        int base;
        base     = 0;
        res_next = res;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            base = 127 - 32 * int'(col_cnt + 2'(k));
            res_next[base -: 32] = mix_col(src[base -: 32], mode);
        end
    end

`ifdef AES_MIXCOL_INV_EN
    // Mode register: captured with the state on the accept edge
    always_ff @(posedge clk) begin
        if (rst) begin
            mode <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            mode <= inv;
        end
    end
`else
    assign mode = 1'b0;
`endif

    // Control FSM with registered handshake outputs, source and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col_cnt   <= 2'd0;
            src       <= '0;
            res       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src      <= in_state;
                        col_cnt  <= 2'd0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    res     <= res_next;
                    col_cnt <= col_cnt + STEP;
                    if (col_cnt == LAST_COL) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_state = res;

endmodule

// File: tb/tb_mixcol_seq.sv
// Self-checking bench for mixcol_seq using directed FIPS-197 style vectors.
module tb_mixcol_seq;

    parameter int CPC = 1;
    localparam int NCYC = 4 / CPC;

    localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
    localparam logic [127:0] COL_IN   = 128'hdb135345f20a225c01010101c6c6c6c6;
    localparam logic [127:0] COL_OUT  = 128'h8e4da1bc9fdc589d01010101c6c6c6c6;
    localparam logic [127:0] ALL80    = {16{8'h80}};

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int n_chk  = 0;
    int n_fail = 0;

    mixcol_seq #(.COLS_PER_CYCLE(CPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .inv       (inv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Send one state with out_ready=1, check latency, data and the single-cycle out_valid
    task automatic run_vec(input string tag, input logic [127:0] din, input logic inv_b,
                           input logic [127:0] exp);
        int lat;
        @(negedge clk);
        chk({tag, "_ready"}, 128'(in_ready), 128'(1));
        in_valid = 1'b1;
        in_state = din;
        inv      = inv_b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        inv      = 1'b0;
        in_state = ~din;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 128'(lat), 128'(NCYC));
        chk({tag, "_out"}, out_state, exp);
        @(posedge clk); #1;
        chk({tag, "_vld_drop"}, 128'(out_valid), 128'(0));
        chk({tag, "_ready_back"}, 128'(in_ready), 128'(1));
    endtask

    initial begin
        logic [127:0] svec [3];
        logic [127:0] sexp [3];
        int w;
        int acc;
        int outc;
        int last;
        logic accept;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_state  = '0;
        inv       = 1'b0;
        out_ready = 1'b1;

        // Reset values
        @(posedge clk); #1;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_out_state", out_state, 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Main forward vectors
        run_vec("fips", FIPS_IN, 1'b0, FIPS_OUT);
        run_vec("cols", COL_IN, 1'b0, COL_OUT);
        run_vec("all80", ALL80, 1'b0, ALL80);

        // inv=1: inverse with the feature, ignored without it
`ifdef AES_MIXCOL_INV_EN
        run_vec("inv", FIPS_OUT, 1'b1, FIPS_IN);
`else
        run_vec("inv_ignored", FIPS_IN, 1'b1, FIPS_OUT);
`endif

        // Backpressure in DONE with in_valid/in_state churn
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_state  = COL_IN;
        @(posedge clk); #1;
        in_valid = 1'b0;
        w = 0;
        while (!out_valid && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        chk("bp_lat", 128'(w), 128'(NCYC));
        chk("bp_out", out_state, COL_OUT);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            in_state = {4{$urandom}};
            @(posedge clk); #1;
            chk("bp_hold_valid", 128'(out_valid), 128'(1));
            chk("bp_hold_state", out_state, COL_OUT);
            chk("bp_hold_ready", 128'(in_ready), 128'(0));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_valid", 128'(out_valid), 128'(0));
        chk("bp_release_ready", 128'(in_ready), 128'(1));
        chk("bp_release_busy", 128'(busy), 128'(0));
        chk("bp_result_held", out_state, COL_OUT);

        // Reset during the second BUSY cycle
        @(negedge clk);
        in_valid = 1'b1;
        in_state = FIPS_IN;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_out_state", out_state, 128'(0));
        rst = 1'b0;
        run_vec("after_rst", COL_IN, 1'b0, COL_OUT);

        // Saturation: in_valid held high, three states back to back
        svec[0] = FIPS_IN; sexp[0] = FIPS_OUT;
        svec[1] = COL_IN;  sexp[1] = COL_OUT;
        svec[2] = ALL80;   sexp[2] = ALL80;
        acc  = 0;
        outc = 0;
        last = -1;
        @(negedge clk);
        in_valid = 1'b1;
        in_state = svec[0];
        for (int c = 0; c < 3 * (NCYC + 2) + 6; c++) begin
            if (out_valid) begin
                if (outc < 3) chk("sat_out", out_state, sexp[outc]);
                outc++;
            end
            accept = in_ready && in_valid;
            if (accept) begin
                if (last >= 0) chk("sat_gap", 128'(c - last), 128'(NCYC + 2));
                last = c;
                acc++;
            end
            @(posedge clk); #1;
            if (accept) begin
                if (acc < 3) in_state = svec[acc];
                else in_valid = 1'b0;
            end
            @(negedge clk);
        end
        chk("sat_accepts", 128'(acc), 128'(3));
        chk("sat_outputs", 128'(outc), 128'(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
